// File: rtl/ct_ciu_fifo_issue.sv
// CIU FIFO drain/issue stage: pops one entry, issues it on req/grant/nack,
// retries on nack and drops after max retries. Option: CT_CIU_FIFO_ISSUE_BACKOFF_EN.
module ct_ciu_fifo_issue #(
  parameter int WIDTH     = 6,
  parameter int RETRY_W   = 3,
  parameter int BACKOFF   = 4,
  parameter int BACKOFF_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fifo_pop_data_vld,
  input  logic [WIDTH-1:0]   fifo_pop_data,
  output logic               fifo_pop_en,
  output logic               issue_req,
  output logic [WIDTH-1:0]   issue_data,
  input  logic               issue_grant,
  input  logic               issue_nack,
  output logic [RETRY_W-1:0] issue_retry_cnt,
  output logic               issue_done,
  output logic               issue_err,
  input  logic               issue_err_clr,
  output logic               issue_busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ
`ifdef CT_CIU_FIFO_ISSUE_BACKOFF_EN
    , S_BACKOFF
`endif
  } state_t;

  localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

  state_t             state_q;
  logic [WIDTH-1:0]   hold_q;
  logic [RETRY_W-1:0] retry_q;
  logic               in_idle;
  logic               in_req;
  logic               nack_take;
  logic               retry_ok;
  logic               drop;

`ifdef CT_CIU_FIFO_ISSUE_BACKOFF_EN
  logic [BACKOFF_W-1:0] bo_q;
`endif

  assign in_idle   = (state_q == S_IDLE);
  assign in_req    = (state_q == S_REQ);
  // grant wins over nack in the same cycle
  assign nack_take = in_req & ~issue_grant & issue_nack;
  assign retry_ok  = nack_take & (retry_q != RETRY_MAX);
  assign drop      = nack_take & (retry_q == RETRY_MAX);

  assign fifo_pop_en = ~rst & fifo_pop_data_vld
                     & (in_idle | (in_req & issue_grant));

  assign issue_req       = in_req;
  assign issue_data      = hold_q;
  assign issue_retry_cnt = retry_q;
  assign issue_busy      = ~in_idle;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hold_q     <= '0;
      retry_q    <= '0;
      issue_done <= 1'b0;
      issue_err  <= 1'b0;
`ifdef CT_CIU_FIFO_ISSUE_BACKOFF_EN
      bo_q       <= '0;
`endif
    end else begin
      issue_done <= in_req & issue_grant;
      issue_err  <= drop | (issue_err & ~issue_err_clr);

      if (fifo_pop_en) begin
        hold_q  <= fifo_pop_data;
        retry_q <= '0;
      end else if (retry_ok) begin
        retry_q <= retry_q + 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (fifo_pop_en) state_q <= S_REQ;
        end
        S_REQ: begin
          if (issue_grant) begin
            state_q <= fifo_pop_en ? S_REQ : S_IDLE;
          end else if (drop) begin
            state_q <= S_IDLE;
          end else if (retry_ok) begin
`ifdef CT_CIU_FIFO_ISSUE_BACKOFF_EN
            state_q <= S_BACKOFF;
            bo_q    <= BACKOFF_W'(BACKOFF - 1);
`else
            state_q <= S_REQ;
`endif
          end
        end
`ifdef CT_CIU_FIFO_ISSUE_BACKOFF_EN
        S_BACKOFF: begin
          if (bo_q == '0) state_q <= S_REQ;
          else            bo_q    <= bo_q - 1'b1;
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
